// File: rtl/fetch_pkg.sv
// Shared constants for the fetch stage: FSM encodings and the branch target/offset tables.
package fetch_pkg;

  localparam int LUT_DEPTH = 8;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Absolute targets are stored wide and truncated to the PC width at the lookup.
  localparam logic [15:0] ABS_LUT [LUT_DEPTH] = '{
    16'd16, 16'd6, 16'd7, 16'd3, 16'd512, 16'd1023, 16'd5, 16'd200
  };

  localparam logic signed [7:0] REL_LUT [LUT_DEPTH] = '{
    8'sd1, 8'sd2, -8'sd3, -8'sd4, 8'sd5, -8'sd1, 8'sd127, 8'sh80
  };

  function automatic logic cond_eval(input logic flag_sel, input logic invert,
                                     input logic zero, input logic negative);
    return (flag_sel ? negative : zero) ^ invert;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Decoder/ALU-facing bus of the fetch stage.
interface fetch_unit_if #(
  parameter int PCW  = 10,
  parameter int CNTW = 16
);
  logic            Start;
  logic            Halt;
  logic            AbsBranch;
  logic            RelBranch;
  logic            BranchFlag;
  logic            BranchInvert;
  logic            Zero;
  logic            Negative;
  logic [2:0]      BranchField;
  logic [PCW-1:0]  ProgCounter;
  logic            Running;
  logic            Done;
  logic            BranchTaken;
  logic [CNTW-1:0] CycleCount;

  modport master (
    output Start, Halt, AbsBranch, RelBranch, BranchFlag, BranchInvert,
           Zero, Negative, BranchField,
    input  ProgCounter, Running, Done, BranchTaken, CycleCount
  );

  modport slave (
    input  Start, Halt, AbsBranch, RelBranch, BranchFlag, BranchInvert,
           Zero, Negative, BranchField,
    output ProgCounter, Running, Done, BranchTaken, CycleCount
  );
endinterface

// File: rtl/fetch_unit_branch_lut.sv
// Combinational branch table lookup: field index to absolute target and signed offset.
module branch_lut
  import fetch_pkg::*;
#(
  parameter int PCW = 10
) (
  input  logic [2:0]     idx,
  output logic [PCW-1:0] abs_target,
  output logic [7:0]     rel_offset
);
  always_comb begin
    abs_target = PCW'(ABS_LUT[idx]);
    rel_offset = REL_LUT[idx];
  end
endmodule

// File: rtl/fetch_unit.sv
// Program counter and run sequencer: IDLE -> RUN -> DONE, branch resolution, cycle counter.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int PCW      = 10,
  parameter int PROG_LEN = 1024,
  parameter int CNTW     = 16
) (
  input logic         Clk,
  input logic         Reset,
  fetch_unit_if.slave bus
);
  localparam logic [PCW-1:0]  LAST = PCW'(PROG_LEN - 1);
  localparam logic [CNTW-1:0] CMAX = '1;

  logic [1:0]      state;
  logic [PCW-1:0]  pc;
  logic [CNTW-1:0] cnt;
  logic [PCW-1:0]  abs_t;
  logic [7:0]      rel_o;
  logic [PCW-1:0]  rel_ext;
  logic            cond;
  logic            taken;

  branch_lut #(.PCW(PCW)) u_lut (
    .idx       (bus.BranchField),
    .abs_target(abs_t),
    .rel_offset(rel_o)
  );

  assign cond    = cond_eval(bus.BranchFlag, bus.BranchInvert, bus.Zero, bus.Negative);
  assign taken   = (state == RUN) & (bus.AbsBranch | bus.RelBranch) & cond;
  // Sign-extend the offset to the PC width so the add wraps modulo 2**PCW.
  assign rel_ext = PCW'($signed(rel_o));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      pc    <= '0;
      cnt   <= '0;
    end else if (bus.Start) begin
      state <= RUN;
      pc    <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      if (cnt != CMAX) cnt <= cnt + 1'b1;
      if (bus.Halt)                 state <= DONE;
      else if (taken && bus.AbsBranch) pc <= abs_t;
      else if (taken)               pc    <= pc + rel_ext;
      else if (pc == LAST)          state <= DONE;
      else                          pc    <= pc + 1'b1;
    end
  end

  assign bus.ProgCounter = pc;
  assign bus.Running     = (state == RUN);
  assign bus.Done        = (state == DONE);
  assign bus.BranchTaken = taken;
  assign bus.CycleCount  = cnt;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a behavioural next-state model checked every cycle.
module tb_fetch_unit;
  localparam int PCW      = 10;
  localparam int PROG_LEN = 8;
  localparam int CNTW     = 4;
  localparam int CMAX     = 15;
  localparam int PCMOD    = 1024;

  logic Clk = 1'b0;
  logic Reset;

  fetch_unit_if #(.PCW(PCW), .CNTW(CNTW)) f ();

  fetch_unit #(.PCW(PCW), .PROG_LEN(PROG_LEN), .CNTW(CNTW)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (f)
  );

  always #5 Clk = ~Clk;

  int n_pass = 0;
  int n_chk  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: state 0=idle 1=run 2=done, PC and count as plain integers.
  int abs_tab [8] = '{16, 6, 7, 3, 512, 1023, 5, 200};
  int rel_tab [8] = '{1, 2, -3, -4, 5, -1, 127, -128};
  int m_st, m_pc, m_cnt, n_st, n_pc, n_cnt;
  bit m_taken;

  always @* begin
    m_taken = (m_st == 1) && (f.AbsBranch || f.RelBranch) &&
              ((f.BranchFlag ? f.Negative : f.Zero) != f.BranchInvert);
    n_st  = m_st;
    n_pc  = m_pc;
    n_cnt = m_cnt;
    if (f.Start) begin
      n_st = 1; n_pc = 0; n_cnt = 0;
    end else if (m_st == 1) begin
      n_cnt = (m_cnt >= CMAX) ? CMAX : m_cnt + 1;
      if (f.Halt)                      n_st = 2;
      else if (m_taken && f.AbsBranch) n_pc = abs_tab[f.BranchField] % PCMOD;
      else if (m_taken)                n_pc = ((m_pc + rel_tab[f.BranchField]) % PCMOD + PCMOD) % PCMOD;
      else if (m_pc == PROG_LEN - 1)   n_st = 2;
      else                             n_pc = (m_pc + 1) % PCMOD;
    end
  end

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_st <= 0; m_pc <= 0; m_cnt <= 0;
    end else begin
      m_st <= n_st; m_pc <= n_pc; m_cnt <= n_cnt;
    end
  end

  always @(negedge Clk) begin
    chk("pc",      32'(f.ProgCounter), 32'(m_pc));
    chk("running", 32'(f.Running),     32'(m_st == 1));
    chk("done",    32'(f.Done),        32'(m_st == 2));
    chk("count",   32'(f.CycleCount),  32'(m_cnt));
    chk("taken",   32'(f.BranchTaken), 32'(m_taken));
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic clr_br();
    f.AbsBranch = 0; f.RelBranch = 0; f.BranchFlag = 0; f.BranchInvert = 0;
    f.Zero = 0; f.Negative = 0; f.BranchField = 3'd0;
  endtask

  task automatic pulse_start();
    f.Start = 1; tick(); f.Start = 0;
  endtask

  initial begin
    Reset = 1; f.Start = 0; f.Halt = 0; clr_br();
    repeat (2) tick();
    Reset = 0;
    chk("rst_pc", 32'(f.ProgCounter), 0);
    chk("rst_run", 32'(f.Running), 0);
    chk("rst_done", 32'(f.Done), 0);
    chk("rst_cnt", 32'(f.CycleCount), 0);

    // Branch inputs ignored while idle
    f.AbsBranch = 1; f.Zero = 1; #1;
    chk("idle_bt", 32'(f.BranchTaken), 0);
    tick();
    chk("idle_pc", 32'(f.ProgCounter), 0);
    clr_br();

    // Straight-line run to end of program
    pulse_start();
    chk("start_run", 32'(f.Running), 1);
    chk("start_pc", 32'(f.ProgCounter), 0);
    repeat (7) tick();
    chk("seq_pc7", 32'(f.ProgCounter), 7);
    chk("seq_cnt7", 32'(f.CycleCount), 7);
    tick();
    chk("end_done", 32'(f.Done), 1);
    chk("end_pc", 32'(f.ProgCounter), 7);
    chk("end_cnt", 32'(f.CycleCount), 8);
    tick();
    chk("frozen_cnt", 32'(f.CycleCount), 8);

    // Relative branch on Zero, offset -3 from PC 5
    pulse_start();
    repeat (5) tick();
    chk("rel_pc5", 32'(f.ProgCounter), 5);
    f.RelBranch = 1; f.Zero = 1; f.BranchField = 3'd2; #1;
    chk("rel_bt", 32'(f.BranchTaken), 1);
    tick();
    chk("rel_pc2", 32'(f.ProgCounter), 2);
    clr_br();

    // Inverted Negative test: not taken, then taken to abs_lut[1]=6
    f.AbsBranch = 1; f.BranchInvert = 1; f.BranchFlag = 1; f.Negative = 1; f.BranchField = 3'd1; #1;
    chk("inv_bt0", 32'(f.BranchTaken), 0);
    tick();
    chk("inv_pc3", 32'(f.ProgCounter), 3);
    f.Negative = 0; #1;
    chk("inv_bt1", 32'(f.BranchTaken), 1);
    tick();
    chk("abs_pc6", 32'(f.ProgCounter), 6);
    clr_br();

    // Negative-flag relative branch, offset -1
    f.RelBranch = 1; f.BranchFlag = 1; f.Negative = 1; f.BranchField = 3'd5;
    tick();
    chk("neg_pc5", 32'(f.ProgCounter), 5);
    clr_br();

    // Wrap below zero, then taken branch at the last address
    pulse_start();
    tick();
    chk("wrap_pc1", 32'(f.ProgCounter), 1);
    f.RelBranch = 1; f.Zero = 1; f.BranchField = 3'd3;
    tick();
    chk("wrap_pc", 32'(f.ProgCounter), 1021);
    clr_br();
    f.AbsBranch = 1; f.Zero = 1; f.BranchField = 3'd2;
    tick();
    chk("last_pc", 32'(f.ProgCounter), 7);
    tick();
    chk("last_br_run", 32'(f.Running), 1);
    chk("last_br_done", 32'(f.Done), 0);
    clr_br();
    tick();
    chk("last_end_done", 32'(f.Done), 1);

    // Halt, restart, then reset mid-run
    pulse_start();
    repeat (3) tick();
    chk("halt_pc3", 32'(f.ProgCounter), 3);
    f.Halt = 1;
    tick();
    chk("halt_done", 32'(f.Done), 1);
    chk("halt_pc", 32'(f.ProgCounter), 3);
    chk("halt_cnt", 32'(f.CycleCount), 4);
    tick();
    chk("halt_hold_cnt", 32'(f.CycleCount), 4);
    f.Halt = 0;
    pulse_start();
    chk("restart_run", 32'(f.Running), 1);
    chk("restart_pc", 32'(f.ProgCounter), 0);
    chk("restart_cnt", 32'(f.CycleCount), 0);
    repeat (2) tick();
    f.AbsBranch = 1; f.Zero = 1;
    Reset = 1; #1;
    chk("mid_rst_pc", 32'(f.ProgCounter), 0);
    chk("mid_rst_run", 32'(f.Running), 0);
    chk("mid_rst_cnt", 32'(f.CycleCount), 0);
    chk("mid_rst_bt", 32'(f.BranchTaken), 0);
    tick();
    Reset = 0; clr_br();
    tick();
    chk("post_rst_idle", 32'(f.Running), 0);

    // Start while running at PC 6
    pulse_start();
    repeat (6) tick();
    chk("rs_pc6", 32'(f.ProgCounter), 6);
    pulse_start();
    chk("rs_pc0", 32'(f.ProgCounter), 0);
    chk("rs_cnt0", 32'(f.CycleCount), 0);
    chk("rs_run", 32'(f.Running), 1);

    // Abs beats Rel; self-loop at PC 5 until the counter saturates
    repeat (5) tick();
    f.AbsBranch = 1; f.RelBranch = 1; f.Zero = 1; f.BranchField = 3'd6;
    repeat (20) tick();
    chk("sat_pc", 32'(f.ProgCounter), 5);
    chk("sat_cnt", 32'(f.CycleCount), CMAX);
    f.Halt = 1;
    tick();
    chk("sat_halt_done", 32'(f.Done), 1);
    chk("sat_halt_cnt", 32'(f.CycleCount), CMAX);
    f.Halt = 0; clr_br();
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
